// File: rtl/crc_stream_master_if.sv
// CFU request/response handshake: the initiator sends one byte plus the running CRC,
// and the responder returns the updated CRC tagged with the request id.
interface cfu_interface;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_id;
    logic [31:0] req_data0;
    logic [31:0] req_data1;
    logic        resp_valid;
    logic        resp_ready;
    logic [3:0]  resp_id;
    logic [1:0]  resp_status;
    logic [31:0] resp_data;

    modport master (
        output req_valid, req_id, req_data0, req_data1, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_status, resp_data
    );

    modport slave (
        input  req_valid, req_id, req_data0, req_data1, resp_ready,
        output req_ready, resp_valid, resp_id, resp_status, resp_data
    );
endinterface

// File: rtl/crc_stream_master.sv
// Streams message bytes through an external CFU CRC engine, one outstanding request
// at a time, and presents the final CRC and an error flag for the whole message.
module crc_stream_master #(
    parameter logic [31:0] INIT_CRC  = 32'hFFFFFFFF,
    parameter logic [31:0] FINAL_XOR = 32'hFFFFFFFF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_crc,
    output logic         out_error,
    cfu_interface.master cfu
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        REQ   = 3'd2,
        RESP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  id_reg;
    logic [31:0] crc_reg;
    logic        err_reg;
    logic [7:0]  byte_reg;
    logic        last_reg;
    logic        resp_bad;

    // id_reg has already advanced past the accepted request, so the issued id is one behind.
    assign resp_bad = (cfu.resp_id != (id_reg - 4'd1)) || (cfu.resp_status != 2'd0);

    assign cfu.req_id    = id_reg;
    assign cfu.req_data0 = {24'b0, byte_reg};
    assign cfu.req_data1 = crc_reg;

    assign out_crc   = crc_reg ^ FINAL_XOR;
    assign out_error = err_reg && (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            id_reg   <= 4'd0;
            crc_reg  <= 32'd0;
            err_reg  <= 1'b0;
            byte_reg <= 8'd0;
            last_reg <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        crc_reg <= INIT_CRC;
                        err_reg <= 1'b0;
                    end
                end
                FETCH: begin
                    if (in_valid) begin
                        byte_reg <= in_data;
                        last_reg <= in_last;
                    end
                end
                REQ: begin
                    if (cfu.req_ready) begin
                        id_reg <= id_reg + 4'd1;
                    end
                end
                RESP: begin
                    if (cfu.resp_valid) begin
                        crc_reg <= cfu.resp_data;
                        if (resp_bad) begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt      = state;
        in_ready       = 1'b0;
        out_valid      = 1'b0;
        cfu.req_valid  = 1'b0;
        cfu.resp_ready = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                cfu.req_valid = 1'b1;
                if (cfu.req_ready) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                cfu.resp_ready = 1'b1;
                // An error ends the message early; remaining bytes are left for upstream to flush.
                if (cfu.resp_valid) begin
                    state_nxt = (last_reg || resp_bad) ? DONE : FETCH;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_crc_stream_master.sv
// Bench for crc_stream_master: CRC-32 responder on the CFU port plus table-driven messages.
module tb_crc_stream_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'd0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_crc;
    logic        out_error;

    cfu_interface cfu_if();

    crc_stream_master dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_crc   (out_crc),
        .out_error (out_error),
        .cfu       (cfu_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reflected CRC-32 byte update (poly 0xEDB88320), as a reference CFU engine would compute.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'b0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    int          rdy_dly = 0;
    int          rsp_dly = 0;
    int          err_at = -1;
    int          badid_at = -1;
    int          req_cnt = 0;
    bit          stab_bad = 1'b0;
    logic [3:0]  log_id[$];
    logic [31:0] log_d0[$];
    logic [31:0] log_d1[$];
    logic [31:0] r_d0, r_d1;
    logic [3:0]  r_id;
    int          r_k;

    initial begin
        cfu_if.req_ready   = 1'b0;
        cfu_if.resp_valid  = 1'b0;
        cfu_if.resp_id     = 4'd0;
        cfu_if.resp_status = 2'd0;
        cfu_if.resp_data   = 32'd0;
        forever begin
            @(negedge clk);
            if (cfu_if.req_valid) begin
                r_d0 = cfu_if.req_data0;
                r_d1 = cfu_if.req_data1;
                r_id = cfu_if.req_id;
                for (int i = 0; i < rdy_dly; i++) begin
                    @(negedge clk);
                    if (!cfu_if.req_valid || cfu_if.req_id !== r_id ||
                        cfu_if.req_data0 !== r_d0 || cfu_if.req_data1 !== r_d1)
                        stab_bad = 1'b1;
                end
                cfu_if.req_ready = 1'b1;
                @(negedge clk);
                cfu_if.req_ready = 1'b0;
                r_k = req_cnt;
                req_cnt++;
                log_id.push_back(r_id);
                log_d0.push_back(r_d0);
                log_d1.push_back(r_d1);
                repeat (rsp_dly) @(negedge clk);
                cfu_if.resp_valid  = 1'b1;
                cfu_if.resp_data   = crc_step(r_d1, r_d0[7:0]);
                cfu_if.resp_id     = (r_k == badid_at) ? r_id + 4'd1 : r_id;
                cfu_if.resp_status = (r_k == err_at) ? 2'd1 : 2'd0;
                @(negedge clk);
                cfu_if.resp_valid  = 1'b0;
            end
        end
    end

    typedef struct packed {
        logic [71:0] data;
        int          len;
        int          rdy;
        int          rsp;
        int          err_at;
        int          badid_at;
        int          hold;
        logic [31:0] exp_crc;
        logic        exp_err;
        int          exp_nreq;
    } vec_t;

    function automatic logic [7:0] byte_at(input logic [71:0] d, input int i);
        return d[71 - 8*i -: 8];
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_msg(input vec_t v, input bit do_reset);
        int idx;
        int guard;
        int nbad;
        bit acc;
        rdy_dly  = v.rdy;
        rsp_dly  = v.rsp;
        err_at   = v.err_at;
        badid_at = v.badid_at;
        req_cnt  = 0;
        stab_bad = 1'b0;
        log_id.delete();
        log_d0.delete();
        log_d1.delete();
        if (do_reset) apply_reset();
        @(negedge clk);
        idx      = 0;
        in_valid = 1'b1;
        in_data  = byte_at(v.data, 0);
        in_last  = (v.len == 1);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!out_valid && guard < 600) begin
            acc = in_ready;
            @(negedge clk);
            guard++;
            if (acc) begin
                idx++;
                if (idx < v.len) begin
                    in_data = byte_at(v.data, idx);
                    in_last = (idx == v.len - 1);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("done_reached", 32'(out_valid), 32'd1);
        chk("out_crc", out_crc, v.exp_crc);
        chk("out_error", 32'(out_error), 32'(v.exp_err));
        chk("req_count", 32'(log_id.size()), 32'(v.exp_nreq));
        nbad = 0;
        foreach (log_id[i]) if (log_id[i] !== 4'(i)) nbad++;
        chk("req_ids_seq", 32'(nbad), 32'd0);
        if (log_d0.size() > 0) begin
            chk("first_req_data0", log_d0[0], {24'b0, byte_at(v.data, 0)});
            chk("first_req_data1", log_d1[0], 32'hFFFFFFFF);
        end
        chk("req_fields_stable", 32'(stab_bad), 32'd0);
        if (v.hold > 0) begin
            nbad = 0;
            for (int i = 0; i < v.hold; i++) begin
                start = (i % 2 == 0);
                @(negedge clk);
                if (!out_valid || out_crc !== v.exp_crc || out_error !== v.exp_err) nbad++;
            end
            start = 1'b0;
            chk("done_hold_stable", 32'(nbad), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_drop", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        nbad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (in_ready || out_valid) nbad++;
        end
        in_valid = 1'b0;
        chk("idle_no_consume", 32'(nbad), 32'd0);
    endtask

    localparam int NV = 8;
    vec_t vecs[NV];

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        int nbad;
        vecs[0] = '{72'h313233343536373839, 9, 0, 0, -1, -1, 0,  32'hCBF43926, 1'b0, 9};
        vecs[1] = '{72'h0,                  1, 0, 0, -1, -1, 0,  32'hD202EF8D, 1'b0, 1};
        vecs[2] = '{72'h313233343536373839, 9, 5, 4, -1, -1, 0,  32'hCBF43926, 1'b0, 9};
        vecs[3] = '{72'h313233343536373839, 9, 0, 0,  2, -1, 0,  32'h884863D2, 1'b1, 3};
        vecs[4] = '{{8'h61, 64'h0},         1, 0, 0, -1, -1, 0,  32'hE8B7BE43, 1'b0, 1};
        vecs[5] = '{{24'h616263, 48'h0},    3, 0, 0, -1,  0, 0,  32'hE8B7BE43, 1'b1, 1};
        vecs[6] = '{{24'h616263, 48'h0},    3, 1, 2, -1, -1, 0,  32'h352441C2, 1'b0, 3};
        vecs[7] = '{{24'h616263, 48'h0},    3, 0, 0, -1, -1, 10, 32'h352441C2, 1'b0, 3};

        // Reset with start asserted in the same cycle: reset wins, outputs at reset values.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_req_valid", 32'(cfu_if.req_valid), 32'd0);
        chk("rst_resp_ready", 32'(cfu_if.resp_ready), 32'd0);
        chk("rst_out_error", 32'(out_error), 32'd0);
        chk("rst_out_crc", out_crc, 32'hFFFFFFFF);

        for (int r = 0; r < NV; r++) run_msg(vecs[r], 1'b1);

        // Reset while waiting for a response; the late response must be ignored.
        rdy_dly  = 0;
        rsp_dly  = 4;
        err_at   = -1;
        badid_at = -1;
        apply_reset();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h31;
        in_last  = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!cfu_if.resp_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_resp", 32'(cfu_if.resp_ready), 32'd1);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_resp_ready", 32'(cfu_if.resp_ready), 32'd0);
        guard = 0;
        while (!cfu_if.resp_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        nbad = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid || cfu_if.resp_ready || cfu_if.req_valid || in_ready) nbad++;
            @(negedge clk);
        end
        chk("late_resp_ignored", 32'(nbad), 32'd0);
        repeat (3) @(negedge clk);
        run_msg(vecs[0], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/crc_stream_master.md
CRC_STREAM_MASTER -- requirements
Module: crc_stream_master

Interface
REQ-001 Parameter INIT_CRC, default 32'hFFFFFFFF, is the running-CRC value loaded on start.
REQ-002 Parameter FINAL_XOR, default 32'hFFFFFFFF, is XORed into the running CRC to form the result.
REQ-003 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, is a synchronous, active-high reset.
REQ-005 Port start, input, 1, is a one-cycle pulse that begins a new message; it is honoured only in IDLE.
REQ-006 Port in_valid, input, 1, marks a valid message byte.
REQ-007 Port in_ready, output, 1, marks that the byte is accepted when in_valid is also high.
REQ-008 Port in_data, input, 8, carries the message byte.
REQ-009 Port in_last, input, 1, marks the final byte of the message.
REQ-010 Port out_valid, output, 1, marks that the result is available.
REQ-011 Port out_ready, input, 1, is the consumer's acceptance of the result.
REQ-012 Port out_crc, output, 32, carries the final CRC.
REQ-013 Port out_error, output, 1, flags a protocol or status error for the message.
REQ-014 Port cfu, cfu_interface.master, carries the initiator side of the CFU request/response handshake.
REQ-015 The cfu fields driven are req_valid, req_id, req_data0, req_data1 and resp_ready; the fields sampled are req_ready, resp_valid, resp_id, resp_status and resp_data.

Function
REQ-016 FSM states are IDLE, FETCH, REQ, RESP and DONE, and exactly one state is active at all times.
REQ-017 IDLE + start: load crc_reg=INIT_CRC, clear err_reg, go to FETCH.
  - start in any state other than IDLE is ignored.
REQ-018 FETCH: in_ready=1.
  - On in_valid, latch in_data into byte_reg and in_last into last_reg, then go to REQ.
  - in_ready=0 in every other state.
REQ-019 REQ: req_valid=1, req_data0={24'b0,byte_reg}, req_data1=crc_reg, req_id=id_reg.
  - These fields stay stable until req_ready is sampled high.
  - On req_valid&req_ready: id_reg<=id_reg+1 (modulo the id width, wrap allowed), go to RESP.
REQ-020 RESP: resp_ready=1; resp_ready=0 in every other state.
  - On resp_valid: crc_reg<=resp_data.
  - If resp_id != the issued id or resp_status != 0, set err_reg.
  - Next state: DONE if last_reg or a new error, else FETCH.
REQ-021 A response arriving in the same cycle the request is accepted is not possible (responder latency ≥1), and the block does not sample it.
REQ-022 Responses outside RESP are ignored.
REQ-023 DONE: out_valid=1, out_crc=crc_reg^FINAL_XOR, out_error=err_reg.
  - On out_ready, go to IDLE.
  - out_crc and out_error are held stable while out_valid&!out_ready.
REQ-024 At most one CFU request is outstanding at any time.
REQ-025 Throughput: one byte per request/response round trip, minimum 3 cycles per byte with a 1-cycle responder.
REQ-026 With in_last=1 on the first byte, the message is a single byte.
REQ-027 Zero-length messages are not supported: DONE is reachable only after at least one byte.
REQ-028 After an error, the remaining bytes of the message are not consumed; upstream must flush them.

Reset
REQ-029 rst forces state IDLE and clears id_reg, crc_reg, err_reg, byte_reg and last_reg to 0.
REQ-030 During and after reset, req_valid=0, resp_ready=0, in_ready=0, out_valid=0, out_error=0 and out_crc=FINAL_XOR^0.
REQ-031 rst asserted mid-operation, including while a request or response is pending, abandons the message.
  - A response arriving later is ignored because the block is in IDLE.
REQ-032 rst takes precedence over start and every handshake in the same cycle.

Verification
REQ-033 Default parameters, reference CRC-32 table responder, message "123456789" (0x31..0x39) -> out_crc=0xCBF43926, out_error=0, exactly 9 CFU requests with ids 0..8.
REQ-034 Single byte 0x00 with in_last=1 -> out_crc=0xD202EF8D, out_error=0.
  - Request observed with req_data0=0x00000000 and req_data1=0xFFFFFFFF.
REQ-035 Responder holds req_ready=0 for 5 cycles and resp_valid=0 for 4 cycles per request -> request fields stable throughout, result unchanged from REQ-033.
REQ-036 Responder returns resp_status=1 on byte 3 of a 9-byte message -> DONE after byte 3 with out_error=1, and in_ready stays 0 thereafter until the next start.
REQ-037 rst pulsed while in RESP, then a late resp_valid arrives -> ignored.
  - A subsequent "123456789" message gives 0xCBF43926 with ids restarting at 0.
REQ-038 out_ready held 0 for 10 cycles in DONE -> out_valid, out_crc and out_error stable.
  - start pulses during those cycles are ignored.
